// File: rtl/pipelined_mac_pe.sv
// Two-stage MAC processing element: per-element products, then accumulate.
// Valid/ready on both sides, signed/unsigned operands, optional saturation.
module pipelined_mac_pe #(
    parameter int InDataWidth  = 8,
    parameter int NumInputs    = 4,
    parameter int OutDataWidth = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NumInputs-1:0][InDataWidth-1:0] a_i,
    input  logic [NumInputs-1:0][InDataWidth-1:0] b_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic                                  signed_i,
    input  logic                                  sat_en_i,
    input  logic                                  init_save_i,
    input  logic                                  last_i,
    input  logic                                  acc_clr_i,
    output logic [OutDataWidth-1:0]               c_o,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic                                  ovf_o
);

    localparam int PW = 2 * InDataWidth;
    localparam int W  = OutDataWidth;

    localparam logic [W-1:0] MaxVal = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};

    typedef struct packed {
        logic                          valid;
        logic                          sgn;
        logic                          sat;
        logic                          init;
        logic                          last;
        logic [NumInputs-1:0][PW-1:0]  prod;
    } s1_t;

    s1_t                          s1_q;
    s1_t                          s1_d;
    logic [NumInputs-1:0][PW-1:0] prod_d;
    logic                         en;
    logic                         accept;
    logic [W:0]                   sum;
    logic [W:0]                   base;
    logic [W:0]                   res;
    logic                         ovf;
    logic [W-1:0]                 acc_q;
    logic [W-1:0]                 acc_d;

    // A pending result that nobody takes freezes the whole pipe.
    assign en         = !(out_valid_o && !out_ready_i);
    assign in_ready_o = en && !acc_clr_i;
    assign accept     = in_valid_i && in_ready_o;
    assign c_o        = acc_q;

    // Low PW bits of the extended product are exact in both modes.
    for (genvar i = 0; i < NumInputs; i++) begin : g_prod
        logic [PW-1:0] ae;
        logic [PW-1:0] be;
        assign ae = {{InDataWidth{signed_i & a_i[i][InDataWidth-1]}}, a_i[i]};
        assign be = {{InDataWidth{signed_i & b_i[i][InDataWidth-1]}}, b_i[i]};
        assign prod_d[i] = ae * be;
    end

    // Bundle the accepted beat for stage 1.
    always_comb begin
        s1_d       = '0;
        s1_d.valid = accept;
        s1_d.sgn   = signed_i;
        s1_d.sat   = sat_en_i;
        s1_d.init  = init_save_i;
        s1_d.last  = last_i;
        s1_d.prod  = prod_d;
    end

    // Stage 1 register; a clear drops whatever beat is in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q <= '0;
        end else if (acc_clr_i) begin
            s1_q.valid <= 1'b0;
        end else if (en) begin
            s1_q <= s1_d;
        end
    end

    // Reduce products and form the next accumulator with one guard bit.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NumInputs; i++) begin
            sum = sum + {{(W+1-PW){s1_q.sgn & s1_q.prod[i][PW-1]}},
                         s1_q.prod[i]};
        end
        base  = s1_q.init ? '0 : {acc_q[W-1], acc_q};
        res   = base + sum;
        ovf   = res[W] ^ res[W-1];
        acc_d = res[W-1:0];
        unique case (1'b1)
            (!ovf || !s1_q.sat):          acc_d = res[W-1:0];
            (ovf && s1_q.sat && res[W]):  acc_d = MinVal;
            (ovf && s1_q.sat && !res[W]): acc_d = MaxVal;
        endcase
    end

    // Stage 2: accumulator, sticky overflow and result valid.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || acc_clr_i) begin
            acc_q       <= '0;
            ovf_o       <= 1'b0;
            out_valid_o <= 1'b0;
        end else begin
            if (en && s1_q.valid) begin
                acc_q <= acc_d;
                if (ovf) begin
                    ovf_o <= 1'b1;
                end else if (s1_q.init) begin
                    ovf_o <= 1'b0;
                end
            end
            if (en && s1_q.valid && s1_q.last) begin
                out_valid_o <= 1'b1;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_mac_pe.sv
// Directed bench for pipelined_mac_pe with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_pipelined_mac_pe;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0][7:0]  a;
    logic [3:0][7:0]  b;
    logic             in_valid;
    logic             in_ready;
    logic             sgn;
    logic             sat;
    logic             init;
    logic             last;
    logic             clr;
    logic [31:0]      c;
    logic             out_valid;
    logic             out_ready;
    logic             ovf;

    int n_cmp = 0;
    int n_bad = 0;

    pipelined_mac_pe #(
        .InDataWidth (8),
        .NumInputs   (4),
        .OutDataWidth(32)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .a_i        (a),
        .b_i        (b),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .signed_i   (sgn),
        .sat_en_i   (sat),
        .init_save_i(init),
        .last_i     (last),
        .acc_clr_i  (clr),
        .c_o        (c),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .ovf_o      (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] av, input logic [31:0] bv,
                         input logic sg, input logic st,
                         input logic ini, input logic lst);
        a        = av;
        b        = bv;
        sgn      = sg;
        sat      = st;
        init     = ini;
        last     = lst;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [31:0] av, input logic [31:0] bv,
                        input logic sg, input logic st,
                        input logic ini, input logic lst);
        drive(av, bv, sg, st, ini, lst);
        tick();
        in_valid = 1'b0;
    endtask

    // Independent dot-product reference.
    function automatic longint dot(input logic [31:0] av,
                                   input logic [31:0] bv, input bit sg);
        longint s = 0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] ea;
            logic [7:0] eb;
            longint     x;
            longint     y;
            ea = av[i*8 +: 8];
            eb = bv[i*8 +: 8];
            x  = sg ? longint'($signed(ea)) : longint'(ea);
            y  = sg ? longint'($signed(eb)) : longint'(eb);
            s += x * y;
        end
        return s;
    endfunction

    // Brings acc to 2^31-100 using unsigned beats, first one init.
    task automatic fill_near_max();
        for (int k = 0; k < 8256; k++) begin
            send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, k == 0, 1'b0);
        end
        send(32'h0004FFFF, 32'h000781FF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        a         = '0;
        b         = '0;
        in_valid  = 1'b0;
        sgn       = 1'b0;
        sat       = 1'b0;
        init      = 1'b0;
        last      = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_c", c, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single signed beat: 1*5+2*6+3*7+4*8
        send(32'h04030201, 32'h08070605, 1'b1, 1'b0, 1'b1, 1'b1);
        check("t1_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        check("t1_c", c, 32'd70);
        check("t1_out_valid", {31'd0, out_valid}, 32'd1);
        tick();
        check("t1_drained", {31'd0, out_valid}, 32'd0);
        check("t1_c_hold", c, 32'd70);

        // Three beats of -1s accumulate to 12
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_c_partial", c, 32'd4);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t2_c_partial2", c, 32'd8);
        check("t2_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        check("t2_c", c, 32'd12);
        check("t2_out_valid", {31'd0, out_valid}, 32'd1);

        // Same bits, unsigned then signed
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check("t3_unsigned", c, 32'd260100);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        check("t3_signed", c, 32'd4);
        check("t3_ovf", {31'd0, ovf}, 32'd0);
        tick();

        // Back-pressure freezes pipe, resumes without loss
        out_ready = 1'b0;
        drive(32'h01010101, 32'h01010101, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        drive(32'h02020202, 32'h03030303, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        drive(32'h03030303, 32'hFEFEFEFE, 1'b1, 1'b0, 1'b1, 1'b1);
        check("t5_first", c, 32'd4);
        check("t5_stall_ready", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        check("t5_frozen_c", c, 32'd4);
        check("t5_frozen_valid", {31'd0, out_valid}, 32'd1);
        check("t5_frozen_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        check("t5_ready_back", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("t5_second", c, 32'd24);
        check("t5_second_valid", {31'd0, out_valid}, 32'd1);
        tick();
        check("t5_third", c, 32'hFFFFFFE8);
        check("t5_third_valid", {31'd0, out_valid}, 32'd1);
        tick();
        check("t5_drained", {31'd0, out_valid}, 32'd0);

        // Saturation at the positive limit
        fill_near_max();
        check("t4_fill", c, 32'h7FFFFF9C);
        check("t4_fill_ovf", {31'd0, ovf}, 32'd0);
        send(32'h00000A0A, 32'h00000A0A, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("t4_sat_c", c, 32'h7FFFFFFF);
        check("t4_sat_ovf", {31'd0, ovf}, 32'd1);

        // Wrap at the positive limit; init refill clears ovf
        fill_near_max();
        check("t4_refill", c, 32'h7FFFFF9C);
        check("t4_refill_ovf", {31'd0, ovf}, 32'd0);
        send(32'h00000A0A, 32'h00000A0A, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("t4_wrap_c", c, 32'h80000064);
        check("t4_wrap_ovf", {31'd0, ovf}, 32'd1);

        // Clear drops in-flight beat and refuses the presented one
        drive(32'h01010101, 32'h01010101, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(32'h05050505, 32'h05050505, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("t6_pre_c", c, 32'h80000068);
        check("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        check("t6_ovf_sticky", {31'd0, ovf}, 32'd1);
        drive(32'h07070707, 32'h07070707, 1'b1, 1'b0, 1'b0, 1'b1);
        clr = 1'b1;
        #1;
        check("t6_clr_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("t6_clr_c", c, 32'd0);
        check("t6_clr_valid", {31'd0, out_valid}, 32'd0);
        check("t6_clr_ovf", {31'd0, ovf}, 32'd0);
        clr      = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        check("t6_dropped_c", c, 32'd0);
        check("t6_dropped_valid", {31'd0, out_valid}, 32'd0);
        send(32'h04030201, 32'h04FD02FF, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check("t6_model", c, 32'(dot(32'h04030201, 32'h04FD02FF, 1'b1)));
        check("t6_const", c, 32'd10);
        check("t6_valid", {31'd0, out_valid}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
